servo_multi_ctrl: RTL and testbench
===================================

Name: servo_multi_ctrl

Overview:
- Parametrised successor of the single-channel servo block for the vending machine.
- Drives NUM_CH hobby servos from one shared PWM frame counter.
- Each channel has its own debounced active-low button and dispense sequencer:
  - slew from rest to active position;
  - hold for a set number of frames;
  - slew back;
  - pulse done.
- Sits between the front-panel buttons / vend logic and the servo output pins.

Parameters:
- NUM_CH, 4, number of independent servo channels.
- CLK_HZ, 50_000_000, clock frequency; CYC_PER_US = CLK_HZ/1_000_000 (integer, ≥1).
- FRAME_US, 20000, PWM frame period in µs.
- MIN_US, 1000, minimum legal pulse width in µs.
- MAX_US, 2000, maximum legal pulse width in µs.
- REST_US, 1000, idle/rest pulse width; MIN_US ≤ REST_US ≤ MAX_US.
- ACTIVE_US, 2000, dispense pulse width; MIN_US ≤ ACTIVE_US ≤ MAX_US. May be below REST_US.
- STEP_US, 100, slew step applied per frame, >0.
- HOLD_FRAMES, 50, frames spent at ACTIVE_US, ≥1.
- DEBOUNCE_CYC, 1_000_000, cycles the synchronised button must be stable before acceptance.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable_button  in  NUM_CH  raw active-low buttons, one per channel, asynchronous to clk.
- servo_out  out  NUM_CH  PWM outputs.
- busy  out  NUM_CH  channel is running a sequence.
- done  out  NUM_CH  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (async, rst=1):
  - servo_out=0, busy=0, done=0.
  - Frame counter=0.
  - All positions=REST_US, all FSMs IDLE, debouncers to released (1).
  - Reset mid-sequence aborts immediately; no done pulse is issued.
- Frame counter:
  - Counts 0..FRAME_US*CYC_PER_US-1 and wraps.
  - frame_start is asserted when count==0.
  - The first cycle after reset release is count 0.
- PWM: servo_out[i] = (count < pos_us[i]*CYC_PER_US), registered output.
- Position update: pos_us[i] changes only on frame_start cycles, so a running pulse is never truncated or extended.
- Button front end, per channel:
  - 2-FF synchroniser, then stability counter.
  - Debounced level updates after DEBOUNCE_CYC consecutive equal samples.
  - Press = debounced 1→0 transition, one cycle.
  - Glitches shorter than DEBOUNCE_CYC are ignored.
- FSM per channel: IDLE → RAMP_OUT → HOLD → RAMP_BACK → IDLE.
  - IDLE: busy=0, pos=REST_US. On press, go to RAMP_OUT next cycle and set busy=1.
  - RAMP_OUT: at each frame_start, pos moves STEP_US toward ACTIVE_US, clamped to ACTIVE_US (direction from sign of ACTIVE_US-REST_US). On the frame_start where pos reaches ACTIVE_US, go to HOLD with hold_cnt=0.
  - HOLD: hold_cnt increments at each frame_start. When it reaches HOLD_FRAMES at a frame_start, go to RAMP_BACK and apply the first back-step on that same frame_start. Exactly HOLD_FRAMES full frames are emitted at ACTIVE_US.
  - RAMP_BACK: steps toward REST_US with clamping. On the frame_start where pos reaches REST_US: done=1 for that cycle, busy=0, state IDLE.
  - If ACTIVE_US==REST_US, RAMP_OUT completes on its first frame_start.
- Presses while busy are discarded (no queueing). A press on the same cycle as done is also discarded.
- Channels are fully independent. Simultaneous presses start simultaneous sequences.
- Width rules:
  - Pulse-width arithmetic in µs uses clog2(MAX_US+1) bits.
  - Comparison is in cycles, width clog2(FRAME_US*CYC_PER_US).
  - Step arithmetic must not wrap: clamp before compare.

Decomposition:
- Package servo_pkg holds:
  - state enum (IDLE, RAMP_OUT, HOLD, RAMP_BACK);
  - helper functions clog2 and us_to_cyc;
  - parameter legality checks (elaboration assertions).
- Sub-module servo_channel holds the per-channel logic: debouncer, FSM, pos register, PWM compare. It takes frame_start and the shared count as inputs.
- The top contains the frame counter and a generate loop over NUM_CH.

Test Plan:
All scenarios use CLK_HZ=1_000_000, FRAME_US=100, MIN_US=10, MAX_US=20, REST_US=10, ACTIVE_US=20, STEP_US=5, HOLD_FRAMES=2, DEBOUNCE_CYC=4, NUM_CH=2.

1. Reset 100 cycles, then release → every channel high exactly 10 cycles per 100-cycle frame; busy=0, done=0.
2. ch0 held low 10 cycles → busy[0]=1 after debounce. Following frames' pulse widths are 15, 20, 20, 15, 10. done[0] pulses once on the frame_start where width returns to 10, then busy[0]=0. ch1 stays at 10.
3. ch0 low-glitch of 2 cycles → no busy, widths stay 10.
4. ch0 and ch1 pressed same cycle → identical 15, 20, 20, 15, 10 sequences and simultaneous done pulses. A second ch0 press during HOLD → ignored, exactly one done.
5. rst asserted mid-HOLD → servo_out=0 and busy=0 immediately. After release, width is 10 with no done pulse.
6. ACTIVE_US=18 → widths 15, 18, 18, 13, 10 (clamping both directions).

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types, width helpers and parameter legality rules for the servo controller.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_OUT  = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_BACK = 2'd3
  } servo_state_e;

  // Ceiling log2; never returns 0 so the result is always usable as a vector width.
  function automatic int clog2(input longint value);
    int     r;
    longint v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic longint us_to_cyc(input longint us, input longint cyc_per_us);
    return us * cyc_per_us;
  endfunction

  // Legal parameter set: every pulse fits inside a frame and all positions are in range.
  function automatic bit params_ok(input int num_ch, input longint clk_hz, input int frame_us,
                                   input int min_us, input int max_us, input int rest_us,
                                   input int active_us, input int step_us, input int hold_frames,
                                   input int debounce_cyc);
    bit ok;
    ok = 1'b1;
    if (num_ch < 1) ok = 1'b0;
    if (clk_hz < 1_000_000) ok = 1'b0;
    if (min_us < 1 || min_us > max_us || max_us > frame_us) ok = 1'b0;
    if (rest_us < min_us || rest_us > max_us) ok = 1'b0;
    if (active_us < min_us || active_us > max_us) ok = 1'b0;
    if (step_us < 1 || hold_frames < 1 || debounce_cyc < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: button synchroniser/debouncer, dispense sequencer, position and PWM.
module servo_channel
  import servo_pkg::*;
#(
  parameter int CYC_PER_US   = 1,
  parameter int REST_US      = 10,
  parameter int ACTIVE_US    = 20,
  parameter int STEP_US      = 5,
  parameter int HOLD_FRAMES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int US_W         = 5,
  parameter int CNT_W        = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             button_n_i,
  input  logic             frame_start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             servo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int DB_W = clog2(DEBOUNCE_CYC + 1);
  localparam int HC_W = clog2(HOLD_FRAMES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HC_W-1:0]  HOLD_P   = HC_W'(HOLD_FRAMES);
  localparam logic [US_W-1:0]  REST_P   = US_W'(REST_US);
  localparam logic [US_W-1:0]  ACTIVE_P = US_W'(ACTIVE_US);
  localparam logic [CNT_W:0]   CYC_P    = (CNT_W + 1)'(CYC_PER_US);

  // Move cur one step toward tgt; the remaining distance is checked first so nothing wraps.
  function automatic logic [US_W-1:0] step_toward(input logic [US_W-1:0] cur,
                                                  input logic [US_W-1:0] tgt);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (c < t) return ((t - c) <= STEP_US) ? tgt : US_W'(c + STEP_US);
    return ((c - t) <= STEP_US) ? tgt : US_W'(c - STEP_US);
  endfunction

  logic [1:0]       sync_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             db_q;
  logic             press;
  servo_state_e     state_q;
  logic [US_W-1:0]  pos_q;
  logic [US_W-1:0]  pos_d;
  logic [HC_W-1:0]  hold_q;
  logic             busy_q;
  logic             done_q;
  logic             servo_q;
  logic [CNT_W:0]   pulse_cyc;

  // Synchronise the raw button and accept a new level only after it has been stable long enough.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      db_cnt_q <= '0;
      db_q     <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], button_n_i};
      if (sync_q[1] == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_q <= '0;
        db_q     <= sync_q[1];
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // A press is the single cycle in which the debounced level falls from released to pressed.
  assign press = db_q & ~sync_q[1] & (db_cnt_q == DB_LAST);

  // Candidate position for the next frame, toward whichever end the current phase is heading.
  always_comb begin
    pos_d = pos_q;
    case (state_q)
      ST_RAMP_OUT:           pos_d = step_toward(pos_q, ACTIVE_P);
      ST_HOLD, ST_RAMP_BACK: pos_d = step_toward(pos_q, REST_P);
      default:               pos_d = pos_q;
    endcase
  end

  // Dispense sequencer; position only changes on frame_start so no pulse is cut or stretched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pos_q   <= REST_P;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_q <= ST_RAMP_OUT;
            busy_q  <= 1'b1;
          end
        end
        ST_RAMP_OUT: begin
          if (frame_start_i) begin
            pos_q <= pos_d;
            if (pos_d == ACTIVE_P) begin
              state_q <= ST_HOLD;
              hold_q  <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (frame_start_i) begin
            hold_q <= hold_q + HC_W'(1);
            if (hold_q + HC_W'(1) == HOLD_P) begin
              state_q <= ST_RAMP_BACK;
              pos_q   <= pos_d;
            end
          end
        end
        ST_RAMP_BACK: begin
          if (frame_start_i) begin
            pos_q <= pos_d;
            if (pos_d == REST_P) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pulse_cyc = (CNT_W + 1)'(pos_q) * CYC_P;

  // Registered PWM compare against the shared frame count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) servo_q <= 1'b0;
    else       servo_q <= ({1'b0, count_i} < pulse_cyc);
  end

  assign servo_o = servo_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/servo_multi_ctrl.sv
// Multi-channel servo controller: one shared PWM frame counter feeding NUM_CH channels.
module servo_multi_ctrl
  import servo_pkg::*;
#(
  parameter int     NUM_CH       = 4,
  parameter longint CLK_HZ       = 50_000_000,
  parameter int     FRAME_US     = 20000,
  parameter int     MIN_US       = 1000,
  parameter int     MAX_US       = 2000,
  parameter int     REST_US      = 1000,
  parameter int     ACTIVE_US    = 2000,
  parameter int     STEP_US      = 100,
  parameter int     HOLD_FRAMES  = 50,
  parameter int     DEBOUNCE_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable_button,
  output logic [NUM_CH-1:0] servo_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int CYC_PER_US = int'(CLK_HZ / 1_000_000);
  localparam int FRAME_CYC  = int'(us_to_cyc(FRAME_US, CYC_PER_US));
  localparam int CNT_W      = clog2(FRAME_CYC);
  localparam int US_W       = clog2(MAX_US + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

  if (!params_ok(NUM_CH, CLK_HZ, FRAME_US, MIN_US, MAX_US, REST_US, ACTIVE_US,
                 STEP_US, HOLD_FRAMES, DEBOUNCE_CYC)) begin : g_param_error
    $error("servo_multi_ctrl: illegal parameter combination");
  end

  logic [CNT_W-1:0] count_q;
  logic             frame_start;

  // Free-running frame counter; the first cycle out of reset is count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count_q <= '0;
    else if (count_q == CNT_LAST) count_q <= '0;
    else                        count_q <= count_q + CNT_W'(1);
  end

  assign frame_start = (count_q == '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_channel #(
      .CYC_PER_US  (CYC_PER_US),
      .REST_US     (REST_US),
      .ACTIVE_US   (ACTIVE_US),
      .STEP_US     (STEP_US),
      .HOLD_FRAMES (HOLD_FRAMES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .US_W        (US_W),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk_i        (clk),
      .rst_i        (rst),
      .button_n_i   (enable_button[i]),
      .frame_start_i(frame_start),
      .count_i      (count_q),
      .servo_o      (servo_out[i]),
      .busy_o       (busy[i]),
      .done_o       (done[i])
    );
  end

endmodule

// File: tb/tb_servo_multi_ctrl.sv
// Bench for servo_multi_ctrl: two instances (active 20 us and 18 us) share the buttons;
// a per-frame reference model predicts width, busy and done for every channel.
module tb_servo_multi_ctrl;

  localparam int NCH   = 2;
  localparam int NM    = 4;   // model channels: A ch0, A ch1, B ch0, B ch1
  localparam int FRAME = 100;
  localparam int REST  = 10;
  localparam int STEP  = 5;
  localparam int HOLD  = 2;
  localparam int W     = 11;  // {done_count[1:0], busy, width[7:0]}

  logic           clk;
  logic           rst;
  logic [NCH-1:0] btn;
  logic [NCH-1:0] so_a, busy_a, done_a;
  logic [NCH-1:0] so_b, busy_b, done_b;
  logic [NM-1:0]  so_all, busy_all, done_all;

  int checks = 0;
  int passes = 0;
  int fc;

  logic [W-1:0] exp_q[NM][$];
  logic [W-1:0] pend_q[NM][$];

  servo_multi_ctrl #(
    .NUM_CH(NCH), .CLK_HZ(1_000_000), .FRAME_US(FRAME), .MIN_US(10), .MAX_US(20),
    .REST_US(REST), .ACTIVE_US(20), .STEP_US(STEP), .HOLD_FRAMES(HOLD), .DEBOUNCE_CYC(4)
  ) dut_a (
    .clk(clk), .rst(rst), .enable_button(btn),
    .servo_out(so_a), .busy(busy_a), .done(done_a)
  );

  servo_multi_ctrl #(
    .NUM_CH(NCH), .CLK_HZ(1_000_000), .FRAME_US(FRAME), .MIN_US(10), .MAX_US(20),
    .REST_US(REST), .ACTIVE_US(18), .STEP_US(STEP), .HOLD_FRAMES(HOLD), .DEBOUNCE_CYC(4)
  ) dut_b (
    .clk(clk), .rst(rst), .enable_button(btn),
    .servo_out(so_b), .busy(busy_b), .done(done_b)
  );

  assign so_all   = {so_b, so_a};
  assign busy_all = {busy_b, busy_a};
  assign done_all = {done_b, done_a};

  // Clock and the bench's own frame position (0 on the first cycle after reset).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) fc <= 0;
    else     fc <= (fc == FRAME - 1) ? 0 : fc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rec(input int d, input int b, input int w);
    return {2'(d), 1'(b), 8'(w)};
  endfunction

  function automatic int step_to(input int p, input int t, input int s);
    if (p < t) return (p + s >= t) ? t : p + s;
    return (p - s <= t) ? t : p - s;
  endfunction

  // Frames that follow an accepted press: ramp out, HOLD frames at active, ramp back, done.
  function automatic void push_sequence(input int m, input int active);
    int p;
    p = REST;
    while (p != active) begin
      p = step_to(p, active, STEP);
      pend_q[m].push_back(rec(0, 1, p));
    end
    for (int h = 1; h < HOLD; h++) pend_q[m].push_back(rec(0, 1, active));
    while (p != REST) begin
      p = step_to(p, REST, STEP);
      if (p == REST) pend_q[m].push_back(rec(1, 0, REST));
      else           pend_q[m].push_back(rec(0, 1, p));
    end
  endfunction

  // Monitor: measure each frame's pulse width, done pulses and final busy, then compare.
  int           hi_cnt[NM];
  int           dn_cnt[NM];
  bit           armed = 1'b0;
  logic [W-1:0] act_rec;
  logic [W-1:0] exp_rec;

  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b0;
    end else begin
      if (fc == 0) begin
        armed = 1'b1;
        for (int m = 0; m < NM; m++) begin
          hi_cnt[m] = 0;
          dn_cnt[m] = 0;
        end
      end
      if (armed) begin
        for (int m = 0; m < NM; m++) begin
          hi_cnt[m] += int'(so_all[m]);
          if (done_all[m] && dn_cnt[m] < 3) dn_cnt[m]++;
        end
        if (fc == FRAME - 1) begin
          for (int m = 0; m < NM; m++) begin
            act_rec = rec(dn_cnt[m], int'(busy_all[m]), hi_cnt[m]);
            if (exp_q[m].size() == 0) begin
              checks++;
              $display("FAIL frame_ch%0d: got %0h with no expectation queued", m, act_rec);
            end else begin
              exp_rec = exp_q[m].pop_front();
              check($sformatf("frame_ch%0d", m), 32'(act_rec), 32'(exp_rec));
            end
          end
        end
      end
    end
  end

  task automatic wait_frame_start();
    int guard;
    guard = 0;
    while (fc != 0 && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if (fc != 0) begin
      checks++;
      $display("FAIL frame_align: got fc=%0d required 0", fc);
    end
  endtask

  // Drive one frame: queue the expectation, then press/glitch buttons early in the frame.
  task automatic run_frame(input logic [NCH-1:0] press, input logic [NCH-1:0] glitch);
    logic [W-1:0] r;
    int ch;
    wait_frame_start();
    for (int m = 0; m < NM; m++) begin
      ch = m % NCH;
      r  = (pend_q[m].size() != 0) ? pend_q[m].pop_front() : rec(0, 0, REST);
      if (press[ch] && pend_q[m].size() == 0) begin
        r[8] = 1'b1;
        push_sequence(m, (m < NCH) ? 20 : 18);
      end
      exp_q[m].push_back(r);
    end
    repeat (10) tick();
    btn = ~(press | glitch);
    repeat (2) tick();
    btn = ~press;
    repeat (8) tick();
    btn = '1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("reset_servo_out", 32'(so_all), 32'h0);
    check("reset_busy", 32'(busy_all), 32'h0);
    check("reset_done", 32'(done_all), 32'h0);
    for (int m = 0; m < NM; m++) begin
      exp_q[m].delete();
      pend_q[m].delete();
    end
    btn = '1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] p;
    logic [NCH-1:0] g;
    rst = 1'b0;
    btn = '1;
    tick();
    do_reset(100);

    // Idle frames at rest width
    repeat (2) run_frame(2'b00, 2'b00);
    // Single dispense on ch0
    run_frame(2'b01, 2'b00);
    repeat (6) run_frame(2'b00, 2'b00);
    // Short glitch is ignored
    run_frame(2'b00, 2'b01);
    repeat (2) run_frame(2'b00, 2'b00);
    // Simultaneous presses, then a ch0 press during HOLD
    run_frame(2'b11, 2'b00);
    run_frame(2'b00, 2'b00);
    run_frame(2'b01, 2'b00);
    repeat (4) run_frame(2'b00, 2'b00);
    // Reset in the middle of HOLD
    run_frame(2'b01, 2'b00);
    run_frame(2'b00, 2'b00);
    wait_frame_start();
    repeat (5) tick();
    check("busy_before_reset", 32'(busy_a[0]), 32'h1);
    do_reset(3);
    repeat (2) run_frame(2'b00, 2'b00);
    // Random presses and glitches
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < NCH; c++) begin
        p[c] = ($urandom_range(0, 2) == 0);
        g[c] = !p[c] && ($urandom_range(0, 5) == 0);
      end
      run_frame(p, g);
    end
    wait_frame_start();
    tick();
    for (int m = 0; m < NM; m++) check($sformatf("leftover_ch%0d", m), 32'(exp_q[m].size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
